// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU register file: default widths, clear-FSM state type
// and the index of the optional hard-wired zero register.
package cpu_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned REG_ZERO   = 0;

    typedef enum logic [0:0] {
        StIdle,
        StClearing
    } clr_state_e;

endpackage

// File: rtl/reg_file_param_if.sv
// Register-file bus: one write port, two read ports, clear request and busy status.
// The master drives writes, read addresses and clear; the slave returns read data and busy.
interface reg_file_param_if
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] waddr;
    logic              write;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              clear;
    logic              busy;

    modport master (
        output wdata, waddr, write, raddr1, raddr2, clear,
        input  rdata1, rdata2, busy
    );

    modport slave (
        input  wdata, waddr, write, raddr1, raddr2, clear,
        output rdata1, rdata2, busy
    );

endinterface

// File: rtl/reg_clear_seq.sv
// Sequential clear engine: walks every register index once, one per cycle, after a
// CLEAR request seen in idle. Busy covers exactly 2**ADDR_W cycles.
module reg_clear_seq
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_idx
);

    clr_state_e        r_state;
    clr_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_last;

    assign w_last = (r_cnt == {ADDR_W{1'b1}});

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A CLEAR arriving while already clearing is ignored; the counter wraps to 0 at the end.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (i_clear) begin
                    w_state_nxt = StClearing;
                    w_cnt_nxt   = '0;
                end
            end
            StClearing: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_last) begin
                    w_state_nxt = StIdle;
                end
            end
        endcase
    end

    always_comb begin
        o_busy    = (r_state == StClearing);
        o_clr_we  = (r_state == StClearing);
        o_clr_idx = r_cnt;
    end

endmodule

// File: rtl/reg_file_param.sv
// Parametrised CPU register file: 1 write / 2 read ports, optional registered reads with
// write bypass, optional hard-wired zero register and a multi-cycle clear engine.
module reg_file_param
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned READ_REG = 0,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    reg_file_param_if.slave        bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_idx;
    logic              w_wr_zero;
    logic              w_wr_acc;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    reg_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (bus.clear),
        .o_busy    (w_busy),
        .o_clr_we  (w_clr_we),
        .o_clr_idx (w_clr_idx)
    );

    assign bus.busy  = w_busy;
    assign w_wr_zero = (ZERO_REG != 0) && (bus.waddr == ADDR_W'(REG_ZERO));
    assign w_wr_acc  = bus.write && !w_busy && !w_wr_zero;

    // Clear strobes only while busy and accepted writes only while idle, so they never collide.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_clr_we) begin
                r_regs[w_clr_idx] <= '0;
            end
            if (w_wr_acc) begin
                r_regs[bus.waddr] <= bus.wdata;
            end
        end
    end

    assign w_rd1 = ((ZERO_REG != 0) && (bus.raddr1 == ADDR_W'(REG_ZERO))) ? '0
                                                                           : r_regs[bus.raddr1];
    assign w_rd2 = ((ZERO_REG != 0) && (bus.raddr2 == ADDR_W'(REG_ZERO))) ? '0
                                                                           : r_regs[bus.raddr2];

    if (READ_REG != 0) begin : g_read_reg
        logic [DATA_W-1:0] r_out1;
        logic [DATA_W-1:0] r_out2;

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_out1 <= '0;
                r_out2 <= '0;
            end else begin
                r_out1 <= (w_wr_acc && (bus.waddr == bus.raddr1)) ? bus.wdata : w_rd1;
                r_out2 <= (w_wr_acc && (bus.waddr == bus.raddr2)) ? bus.wdata : w_rd2;
            end
        end

        assign bus.rdata1 = r_out1;
        assign bus.rdata2 = r_out2;
    end else begin : g_read_comb
        assign bus.rdata1 = w_rd1;
        assign bus.rdata2 = w_rd2;
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: a combinational-read instance and a registered-read,
// zero-register instance share one stimulus stream.
module tb_reg_file_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       write;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [2:0] raddr1;
    logic [2:0] raddr2;
    logic       clear;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_file_param_if #(.DATA_W(8), .ADDR_W(3)) u_if_c ();
    reg_file_param_if #(.DATA_W(8), .ADDR_W(3)) u_if_r ();

    assign u_if_c.wdata  = wdata;
    assign u_if_c.waddr  = waddr;
    assign u_if_c.write  = write;
    assign u_if_c.raddr1 = raddr1;
    assign u_if_c.raddr2 = raddr2;
    assign u_if_c.clear  = clear;
    assign u_if_r.wdata  = wdata;
    assign u_if_r.waddr  = waddr;
    assign u_if_r.write  = write;
    assign u_if_r.raddr1 = raddr1;
    assign u_if_r.raddr2 = raddr2;
    assign u_if_r.clear  = clear;

    reg_file_param #(
        .DATA_W   (8),
        .ADDR_W   (3),
        .READ_REG (0),
        .ZERO_REG (0)
    ) u_dut_c (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (u_if_c.slave)
    );

    reg_file_param #(
        .DATA_W   (8),
        .ADDR_W   (3),
        .READ_REG (1),
        .ZERO_REG (1)
    ) u_dut_r (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (u_if_r.slave)
    );

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] a1;
        logic [2:0] a2;
        logic [7:0] c1;  // comb instance, before the edge
        logic [7:0] c2;
        logic [7:0] r1;  // registered instance, after the edge
        logic [7:0] r2;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 8; a++) begin
            raddr1 = 3'(a);
            raddr2 = 3'(7 - a);
            #1;
            chk({tag, " comb out1"}, u_if_c.rdata1, 8'h00);
            chk({tag, " comb out2"}, u_if_c.rdata2, 8'h00);
            cycle();
            chk({tag, " reg out1"}, u_if_r.rdata1, 8'h00);
            chk({tag, " reg out2"}, u_if_r.rdata2, 8'h00);
        end
    endtask

    task automatic fill_ff();
        for (int a = 0; a < 8; a++) begin
            write = 1'b1;
            waddr = 3'(a);
            wdata = 8'hFF;
            cycle();
        end
        write = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    initial begin
        int n;
        int nc;
        int nr;

        vecs[0] = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd7, 8'h00, 8'h00, 8'hA5, 8'h00};
        vecs[1] = '{1'b1, 3'd7, 8'h3C, 3'd3, 3'd7, 8'hA5, 8'h00, 8'hA5, 8'h3C};
        vecs[2] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[3] = '{1'b1, 3'd5, 8'h11, 3'd5, 3'd3, 8'h00, 8'hA5, 8'h11, 8'hA5};
        vecs[4] = '{1'b1, 3'd5, 8'h77, 3'd5, 3'd7, 8'h11, 8'h3C, 8'h77, 8'h3C};
        vecs[5] = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd1, 8'h77, 8'h00, 8'h77, 8'h00};
        vecs[6] = '{1'b1, 3'd1, 8'hEE, 3'd2, 3'd1, 8'h00, 8'h00, 8'h00, 8'hEE};
        vecs[7] = '{1'b0, 3'd0, 8'h00, 3'd1, 3'd0, 8'hEE, 8'h00, 8'hEE, 8'h00};

        reset  = 1'b1;
        write  = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr1 = '0;
        raddr2 = '0;
        clear  = 1'b0;

        // Reset: outputs and busy cleared, every register reads zero
        cycle();
        reset = 1'b0;
        chk("reset reg out1", u_if_r.rdata1, 8'h00);
        chk("reset reg out2", u_if_r.rdata2, 8'h00);
        chk("reset busy c", {7'b0, u_if_c.busy}, 8'h00);
        chk("reset busy r", {7'b0, u_if_r.busy}, 8'h00);
        read_all_zero("reset");

        // Writes, reads and same-edge bypass
        for (int i = 0; i < 8; i++) begin
            write  = vecs[i].we;
            waddr  = vecs[i].wa;
            wdata  = vecs[i].wd;
            raddr1 = vecs[i].a1;
            raddr2 = vecs[i].a2;
            #1;
            chk($sformatf("vec%0d comb out1", i), u_if_c.rdata1, vecs[i].c1);
            chk($sformatf("vec%0d comb out2", i), u_if_c.rdata2, vecs[i].c2);
            cycle();
            chk($sformatf("vec%0d reg out1", i), u_if_r.rdata1, vecs[i].r1);
            chk($sformatf("vec%0d reg out2", i), u_if_r.rdata2, vecs[i].r2);
        end
        write = 1'b0;

        // Clear: 8 busy cycles, mid-sequence write dropped, repeated CLEAR ignored
        fill_ff();
        raddr1 = 3'd7;
        #1;
        chk("fill comb r7", u_if_c.rdata1, 8'hFF);
        pulse_clear();
        n  = 0;
        nc = 0;
        nr = 0;
        while ((u_if_c.busy || u_if_r.busy) && n < 20) begin
            if (u_if_c.busy) nc++;
            if (u_if_r.busy) nr++;
            n++;
            write = (n == 3);
            waddr = 3'd6;
            wdata = 8'h42;
            clear = (n == 5);
            if (n == 3) begin
                raddr1 = 3'd1;
                raddr2 = 3'd7;
                #1;
                chk("mid clear comb r1", u_if_c.rdata1, 8'h00);
                chk("mid clear comb r7", u_if_c.rdata2, 8'hFF);
            end
            cycle();
        end
        write = 1'b0;
        clear = 1'b0;
        chk("clear busy cycles c", 8'(nc), 8'd8);
        chk("clear busy cycles r", 8'(nr), 8'd8);
        chk("after clear busy c", {7'b0, u_if_c.busy}, 8'h00);
        read_all_zero("after clear");

        // Reset on the third busy cycle aborts the clear
        fill_ff();
        pulse_clear();
        cycle();
        cycle();
        chk("3rd busy cycle c", {7'b0, u_if_c.busy}, 8'h01);
        chk("3rd busy cycle r", {7'b0, u_if_r.busy}, 8'h01);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("abort busy c", {7'b0, u_if_c.busy}, 8'h00);
        chk("abort busy r", {7'b0, u_if_r.busy}, 8'h00);
        read_all_zero("abort");
        write  = 1'b1;
        waddr  = 3'd2;
        wdata  = 8'h09;
        raddr1 = 3'd2;
        raddr2 = 3'd2;
        cycle();
        write = 1'b0;
        chk("post abort comb r2", u_if_c.rdata1, 8'h09);
        chk("post abort reg r2 bypass", u_if_r.rdata1, 8'h09);
        cycle();
        chk("post abort reg r2", u_if_r.rdata2, 8'h09);

        // Zero register: write to reg0 dropped only on the ZERO_REG instance
        write  = 1'b1;
        waddr  = 3'd0;
        wdata  = 8'hEE;
        raddr1 = 3'd0;
        raddr2 = 3'd1;
        cycle();
        chk("zero write comb r0", u_if_c.rdata1, 8'hEE);
        chk("zero write reg r0", u_if_r.rdata1, 8'h00);
        waddr = 3'd1;
        cycle();
        write = 1'b0;
        chk("zero reg r1 bypass", u_if_r.rdata2, 8'hEE);
        cycle();
        chk("zero reg r0 held", u_if_r.rdata1, 8'h00);
        chk("zero reg r1", u_if_r.rdata2, 8'hEE);
        chk("zero comb r1", u_if_c.rdata2, 8'hEE);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
